// File: rtl/fptd_frame_ctrl_if.sv
// Handshake and data bundle between the frame controller and its frame source.
// FPTD_LLR_OUT_EN adds the latched soft-output bus Llr_out.
interface fptd_frame_ctrl_if #(
   parameter int N     = 6,
   parameter int M     = 6,
   parameter int K     = 104,
   parameter int DCMAX = 100
);
   localparam int W  = ((N > M) ? N : M) + 2;
   localparam int IW = $clog2(DCMAX + 1);

   logic                        nClear;
   logic                        Start;
   logic                        Enable;
   logic signed [K-1:0][N-1:0]  ba_sys;
   logic signed [K-1:0][M-1:0]  be_u;
   logic signed [K-1:0][M-1:0]  be_l;

   logic                        Sec_nClear;
   logic                        Sec_Enable;
   logic                        Busy;
   logic                        Done;
   logic                        Early;
   logic [IW-1:0]               Iterations;
   logic [K-1:0]                Decoded;
`ifdef FPTD_LLR_OUT_EN
   logic signed [K-1:0][W-1:0]  Llr_out;
`endif

   modport master (
      output nClear, Start, Enable, ba_sys, be_u, be_l,
      input  Sec_nClear, Sec_Enable, Busy, Done, Early, Iterations, Decoded
`ifdef FPTD_LLR_OUT_EN
      , Llr_out
`endif
   );

   modport slave (
      input  nClear, Start, Enable, ba_sys, be_u, be_l,
      output Sec_nClear, Sec_Enable, Busy, Done, Early, Iterations, Decoded
`ifdef FPTD_LLR_OUT_EN
      , Llr_out
`endif
   );
endinterface

// File: rtl/fptd_frame_ctrl.sv
// Frame control and hard-decision stage of the fully-parallel turbo decoder.
// FPTD_LLR_OUT_EN: also latch the per-bit a-posteriori sums onto Llr_out.
module fptd_frame_ctrl #(
   parameter int N        = 6,
   parameter int M        = 6,
   parameter int K        = 104,
   parameter int DCMAX    = 100,
   parameter int STABLE_N = 2
) (
   input logic               Clock,
   input logic               nReset,
   fptd_frame_ctrl_if.slave  bus
);
   localparam int W  = ((N > M) ? N : M) + 2;
   localparam int IW = $clog2(DCMAX + 1);
   localparam int MW = $clog2(STABLE_N + 1);

   localparam logic [IW-1:0] CAP_V    = IW'(DCMAX);
   localparam logic [MW-1:0] STABLE_V = MW'(STABLE_N - 1);

   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

   state_t                      state, state_nxt;
   logic [IW-1:0]               iter_cnt;
   logic [MW-1:0]               match_cnt, match_cnt_nxt;
   logic [K-1:0]                hard, hard_prev;
   logic signed [K-1:0][W-1:0]  sum;
   logic                        match, stable_hit, cap_hit, terminate;

   logic                        early_q;
   logic [IW-1:0]               iterations_q;
   logic [K-1:0]                decoded_q;

   // Three-way sum is two bits wider than the widest operand, so it never wraps.
   always_comb begin
      sum  = '0;
      hard = '0;
      for (int i = 0; i < K; i++) begin
         sum[i]  = W'($signed(bus.ba_sys[i])) + W'($signed(bus.be_u[i]))
                 + W'($signed(bus.be_l[i]));
         hard[i] = !sum[i][W-1] && (sum[i] != '0);
      end
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt     = state;
      match         = (iter_cnt != '0) && (hard == hard_prev);
      match_cnt_nxt = match ? match_cnt + MW'(1) : '0;
      stable_hit    = (match_cnt_nxt == STABLE_V);
      cap_hit       = ((iter_cnt + IW'(1)) == CAP_V);
      terminate     = (state == RUN) && bus.Enable && (stable_hit || cap_hit);
      unique case (state)
         IDLE:    if (bus.Start) state_nxt = CLR;
         CLR:     state_nxt = RUN;
         RUN:     if (terminate) state_nxt = DONE;
         DONE:    if (bus.Start) state_nxt = CLR;
         default: state_nxt = IDLE;
      endcase
      if (!bus.nClear) state_nxt = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignment so all registers update together.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) state <= IDLE;
      else         state <= state_nxt;
   end

`ifdef FPTD_LLR_OUT_EN
   logic signed [K-1:0][W-1:0] llr_q;
`endif

   // NOTE: the wide decision registers are reset because their zero value is visible on the ports.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         iter_cnt     <= '0;
         match_cnt    <= '0;
         hard_prev    <= '0;
         early_q      <= 1'b0;
         iterations_q <= '0;
         decoded_q    <= '0;
`ifdef FPTD_LLR_OUT_EN
         llr_q        <= '0;
`endif
      end else if (!bus.nClear) begin
         iter_cnt     <= '0;
         match_cnt    <= '0;
         hard_prev    <= '0;
         early_q      <= 1'b0;
         iterations_q <= '0;
         decoded_q    <= '0;
`ifdef FPTD_LLR_OUT_EN
         llr_q        <= '0;
`endif
      end else if (state == CLR) begin
         iter_cnt  <= '0;
         match_cnt <= '0;
         hard_prev <= '0;
      end else if (state == RUN && bus.Enable) begin
         iter_cnt  <= iter_cnt + IW'(1);
         match_cnt <= match_cnt_nxt;
         hard_prev <= hard;
         if (terminate) begin
            decoded_q    <= hard;
            iterations_q <= iter_cnt + IW'(1);
            early_q      <= stable_hit;
`ifdef FPTD_LLR_OUT_EN
            llr_q        <= sum;
`endif
         end
      end
   end

   // Section controls decode the state register; Sec_Enable follows Enable so sections stall in step.
   assign bus.Sec_nClear = (state != CLR);
   assign bus.Sec_Enable = (state == RUN) && bus.Enable;
   assign bus.Busy       = (state == CLR) || (state == RUN);
   assign bus.Done       = (state == DONE);
   assign bus.Early      = early_q;
   assign bus.Iterations = iterations_q;
   assign bus.Decoded    = decoded_q;
`ifdef FPTD_LLR_OUT_EN
   assign bus.Llr_out    = llr_q;
`endif

endmodule

// File: doc/fptd_frame_ctrl.md
Name: fptd_frame_ctrl

Overview:
- Frame-level control and decision stage wrapped around the array of Section_Pipe instances in the fully-parallel turbo decoder.
- Drives the shared nClear/Enable of all K sections.
- Each decoding cycle: combines per-bit systematic LLR with upper and lower extrinsic LLRs (be1 outputs, lower already deinterleaved), forms hard decisions, applies early termination or a DCMAX iteration cap, then latches the decoded frame.

Parameters:
- N, 6, width of channel/a-priori LLRs (ba_sys).
- M, 6, width of extrinsic LLRs (be_u, be_l).
- K, 104, frame length = number of sections.
- DCMAX, 100, maximum decoding cycles per frame (>=2).
- STABLE_N, 2, consecutive identical decision vectors that terminate early (>=2).

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- nClear  in  1  synchronous active-low clear; forces IDLE.
- Start  in  1  one-cycle pulse; begins decoding the frame currently on the inputs.
- Enable  in  1  stall control; 0 freezes RUN progress.
- ba_sys  in  [K-1:0][N-1:0] signed  systematic LLR per bit.
- be_u  in  [K-1:0][M-1:0] signed  upper-decoder extrinsic (section be1).
- be_l  in  [K-1:0][M-1:0] signed  lower-decoder extrinsic, deinterleaved.
- Sec_nClear  out  1  to all sections' nClear.
- Sec_Enable  out  1  to all sections' Enable.
- Busy  out  1  high in CLR or RUN.
- Done  out  1  high in DONE.
- Early  out  1  last frame terminated by stability, not by DCMAX.
- Iterations  out  $clog2(DCMAX+1)  decoding cycles used by last frame.
- Decoded  out  [K-1:0]  hard-decided frame.

Behaviour:
- Reset (nReset=0, async): state IDLE; Sec_nClear=1, Sec_Enable=0, Busy=0, Done=0, Early=0, Iterations=0, Decoded=0; internal iter_cnt, match_cnt, hard_prev cleared.
- Registered outputs; all state changes on the rising Clock edge.
- States and transitions:
  - IDLE: Start=1 -> CLR.
  - CLR: one cycle, Sec_nClear=0, Sec_Enable=0; clears iter_cnt, match_cnt, hard_prev; -> RUN.
  - RUN: Sec_nClear=1, Sec_Enable=Enable. Enable=0 holds all counters and state.
  - DONE: outputs held; Start=1 -> CLR (back-to-back frames, no IDLE needed).
- Start in CLR or RUN is ignored.
- nClear=0 (synchronous, highest priority after reset) from any state -> IDLE with all outputs at reset values.
- Decision arithmetic per bit i:
  - sum_i = sext(ba_sys[i]) + sext(be_u[i]) + sext(be_l[i]), width max(N,M)+2 bits, no saturation (cannot overflow).
  - hard_i = 1 if sum_i > 0, else 0 (zero maps to 0).
- RUN cycle with Enable=1:
  - iter_cnt += 1; hard_prev <= hard.
  - match = (iter_cnt != 0) && (hard == hard_prev).
  - match_cnt_next = match ? match_cnt+1 : 0.
  - Terminate if match_cnt_next == STABLE_N-1 (Early=1) or iter_cnt+1 == DCMAX (Early=0).
  - If both conditions are true in the same cycle, Early=1.
  - On terminate: -> DONE; Decoded <= hard; Iterations <= iter_cnt+1; Done=1 the next cycle.
- Sample timing: the first RUN sample uses the sections' cleared extrinsics (zero); it counts as an iteration but is never a match.
- Reset mid-RUN: immediate return to reset values; the frame is abandoned.

Optional Feature:
- Macro FPTD_LLR_OUT_EN.
- Defined: extra output Llr_out [K-1:0][max(N,M)+1:0] signed, latched with Decoded on terminate, resets to 0.
- Not defined: port absent, no additional registers.

Test Plan:
- Early stop: K=104, ba_sys all +5, be_u=be_l=0, Start -> CLR 1 cycle (Sec_nClear=0), RUN 2 cycles, Done=1, Early=1, Iterations=2, Decoded all ones.
- Cap: ba_sys toggling between all +5 and all -5 each cycle -> Done after 100 RUN cycles, Early=0, Iterations=100.
- Sign/zero: ba_sys[0]=3, be_u[0]=-2, be_l[0]=-1 (sum 0); ba_sys[1]=-32, be_u[1]=31, be_l[1]=2 (sum 1) -> Decoded[0]=0, Decoded[1]=1.
- Stall: constant inputs, Enable=0 for 5 cycles mid-RUN -> Sec_Enable=0 during the stall, Iterations still 2, Done delayed by 5 cycles.
- Clear/restart: nClear=0 in RUN -> next cycle IDLE, Busy=0, outputs zero. Start in DONE -> CLR, Done drops next cycle.
- Async reset: nReset low for 0.25 cycle mid-RUN -> outputs zero immediately, IDLE thereafter, a new Start works.
